// File: rtl/zcash_fpga_pkg.sv
// Shared definitions for the host command path.
//   command_t    : command / reply codes carried in header_t.cmd
//   header_t     : first word of every packet (cmd [63:32], len [31:0] in bytes)
//   rx_route_t   : where the command receiver sends a packet
//   rx_state_t   : command receiver FSM states
//   get_rx_route : route decode of a header (pure function)
//   hdr_words    : number of 64-bit words a header announces
package zcash_fpga_pkg;

  localparam bit ENB_VERIFY_EQUIHASH      = 1'b1;
  localparam bit ENB_VERIFY_SECP256K1_SIG = 1'b1;

  typedef enum logic [31:0] {
    RESET_FPGA               = 32'h0000_0000,
    FPGA_STATUS              = 32'h0000_0001,
    VERIFY_EQUIHASH          = 32'h0000_0100,
    VERIFY_SECP256K1_SIG     = 32'h0000_0101,
    RESET_FPGA_RPL           = 32'h8000_0000,
    FPGA_STATUS_RPL          = 32'h8000_0001,
    FPGA_IGNORE_RPL          = 32'h8000_0002,
    VERIFY_EQUIHASH_RPL      = 32'h8000_0100,
    VERIFY_SECP256K1_SIG_RPL = 32'h8000_0101
  } command_t;

  typedef struct packed {
    logic [31:0] cmd;
    logic [31:0] len;
  } header_t;

  typedef enum logic [1:0] {
    ROUTE_TYP0,
    ROUTE_TYP1,
    ROUTE_DROP
  } rx_route_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_DROP,
    S_IGN
  } rx_state_t;

  // Reply codes (bit31 set) and disabled features fall through to DROP.
  function automatic rx_route_t get_rx_route(header_t hdr, int max_len);
    rx_route_t r;
    r = ROUTE_DROP;
    case (hdr.cmd)
      RESET_FPGA, FPGA_STATUS: r = ROUTE_TYP0;
      VERIFY_EQUIHASH:         if (ENB_VERIFY_EQUIHASH) r = ROUTE_TYP1;
      VERIFY_SECP256K1_SIG:    if (ENB_VERIFY_SECP256K1_SIG) r = ROUTE_TYP1;
      default:                 r = ROUTE_DROP;
    endcase
    if (hdr.len < 32'd8 || hdr.len > $unsigned(max_len)) r = ROUTE_DROP;
    return r;
  endfunction

  // Widened to 33 bits so a len near 2^32 cannot wrap to a small count.
  function automatic logic [31:0] hdr_words(header_t hdr);
    logic [32:0] s;
    s = {1'b0, hdr.len} + 33'd7;
    return s[32:3];
  endfunction

endpackage

// File: rtl/zcash_fpga_cmd_rx.sv
// Host-to-FPGA command receiver and dispatcher.
// Decodes the header on the first word of each host packet and forwards the
// packet with zero latency to the control sink (typ0) or the verify sink
// (typ1). Malformed or unsupported packets are consumed and an ignore reply
// carrying the offending header is requested.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_rx_dat/val/sop/eop, o_rx_rdy      inbound host stream
//   o_typ0_dat/val/sop/eop, i_typ0_rdy  control stream (RESET_FPGA, FPGA_STATUS)
//   o_typ1_dat/val/sop/eop, i_typ1_rdy  verify stream (EQUIHASH, SECP256K1)
//   o_ign_hdr, o_ign_val, i_ign_rdy     ignore-reply request
//   o_err_len, o_err_sop                one-cycle error pulses
//   o_err_cnt                           saturating count of ignores and errors
module zcash_fpga_cmd_rx
  import zcash_fpga_pkg::*;
#(
  parameter int MAX_LEN      = 2048,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [63:0]             i_rx_dat,
  input  logic                    i_rx_val,
  input  logic                    i_rx_sop,
  input  logic                    i_rx_eop,
  output logic                    o_rx_rdy,
  output logic [63:0]             o_typ0_dat,
  output logic                    o_typ0_val,
  output logic                    o_typ0_sop,
  output logic                    o_typ0_eop,
  input  logic                    i_typ0_rdy,
  output logic [63:0]             o_typ1_dat,
  output logic                    o_typ1_val,
  output logic                    o_typ1_sop,
  output logic                    o_typ1_eop,
  input  logic                    i_typ1_rdy,
  output logic [63:0]             o_ign_hdr,
  output logic                    o_ign_val,
  input  logic                    i_ign_rdy,
  output logic                    o_err_len,
  output logic                    o_err_sop,
  output logic [ERR_CNT_BITS-1:0] o_err_cnt
);

  function automatic logic [ERR_CNT_BITS-1:0] sat_inc(input logic [ERR_CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rx_state_t                state_q, state_d;
  logic [15:0]              exp_q, exp_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     sel_typ1_q, sel_typ1_d;
  logic                     no_ign_q, no_ign_d;
  logic [63:0]              ign_hdr_q, ign_hdr_d;
  logic [ERR_CNT_BITS-1:0]  err_cnt_q;

  header_t                  hdr;
  rx_route_t                route;
  logic [15:0]              hdr_exp;
  logic [15:0]              wcnt;

  logic                     rx_rdy;
  logic                     fwd_val, fwd_sop, fwd_eop, fwd_typ1;
  logic                     ign_val, err_sop, err_len, ign_done;

  assign hdr     = header_t'(i_rx_dat);
  assign route   = get_rx_route(hdr, MAX_LEN);
  assign hdr_exp = 16'(hdr_words(hdr));
  // Index of the word currently presented; the header word is number 1.
  assign wcnt    = cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    sel_typ1_d = sel_typ1_q;
    no_ign_d   = no_ign_q;
    ign_hdr_d  = ign_hdr_q;
    rx_rdy     = 1'b0;
    fwd_val    = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = 1'b0;
    fwd_typ1   = sel_typ1_q;
    ign_val    = 1'b0;
    err_sop    = 1'b0;
    err_len    = 1'b0;
    ign_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!i_rx_sop) begin
          rx_rdy  = 1'b1;
          err_sop = i_rx_val;
        end else if (route == ROUTE_DROP) begin
          rx_rdy = 1'b1;
          if (i_rx_val) begin
            ign_hdr_d = i_rx_dat;
            no_ign_d  = 1'b0;
            state_d   = i_rx_eop ? S_IGN : S_DROP;
          end
        end else begin
          fwd_typ1 = (route == ROUTE_TYP1);
          rx_rdy   = fwd_typ1 ? i_typ1_rdy : i_typ0_rdy;
          fwd_val  = i_rx_val;
          fwd_sop  = 1'b1;
          fwd_eop  = (hdr_exp == 16'd1) || i_rx_eop;
          if (i_rx_val && rx_rdy) begin
            exp_d      = hdr_exp;
            cnt_d      = 16'd1;
            sel_typ1_d = fwd_typ1;
            // A multi-word header arriving with eop is a short packet.
            if (hdr_exp != 16'd1) begin
              if (i_rx_eop) err_len = 1'b1;
              else          state_d = S_FWD;
            end
          end
        end
      end

      S_FWD: begin
        rx_rdy  = sel_typ1_q ? i_typ1_rdy : i_typ0_rdy;
        fwd_val = i_rx_val;
        fwd_eop = (wcnt == exp_q) || i_rx_eop;
        if (i_rx_val && rx_rdy) begin
          cnt_d = wcnt;
          if (wcnt == exp_q) begin
            if (i_rx_eop) begin
              state_d = S_IDLE;
            end else begin
              // Long packet: the sink already saw eop, discard the tail quietly.
              err_len  = 1'b1;
              no_ign_d = 1'b1;
              state_d  = S_DROP;
            end
          end else if (i_rx_eop) begin
            err_len = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_DROP: begin
        rx_rdy = 1'b1;
        if (i_rx_val && i_rx_eop) state_d = no_ign_q ? S_IDLE : S_IGN;
      end

      S_IGN: begin
        ign_val = 1'b1;
        if (i_ign_rdy) begin
          ign_done = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are combinational from the host inputs, so they are
  // masked while reset is held to keep them low regardless of the host.
  assign o_rx_rdy   = i_rst_n & rx_rdy;
  assign o_typ0_dat = i_rx_dat;
  assign o_typ0_val = i_rst_n & fwd_val & ~fwd_typ1;
  assign o_typ0_sop = fwd_sop;
  assign o_typ0_eop = fwd_eop;
  assign o_typ1_dat = i_rx_dat;
  assign o_typ1_val = i_rst_n & fwd_val & fwd_typ1;
  assign o_typ1_sop = fwd_sop;
  assign o_typ1_eop = fwd_eop;
  assign o_ign_hdr  = ign_hdr_q;
  assign o_ign_val  = i_rst_n & ign_val;
  assign o_err_len  = i_rst_n & err_len;
  assign o_err_sop  = i_rst_n & err_sop;
  assign o_err_cnt  = err_cnt_q;

  // ---- control registers ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      no_ign_q  <= 1'b0;
      ign_hdr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      no_ign_q  <= no_ign_d;
      ign_hdr_q <= ign_hdr_d;
      // Coincident events in one cycle count once.
      if (err_sop || err_len || ign_done) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  // ---- packet bookkeeping, only meaningful while in FWD ----
  always_ff @(posedge i_clk) begin
    exp_q      <= exp_d;
    cnt_q      <= cnt_d;
    sel_typ1_q <= sel_typ1_d;
  end

endmodule

// File: tb/tb_zcash_fpga_cmd_rx.sv
// Scoreboard bench for zcash_fpga_cmd_rx: stimulus pushes expected beats,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_zcash_fpga_cmd_rx;

  localparam int MAX_LEN = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rx_dat;
  logic        rx_val, rx_sop, rx_eop;
  logic        rx_rdy;
  logic [63:0] typ0_dat, typ1_dat, ign_hdr;
  logic        typ0_val, typ0_sop, typ0_eop, typ0_rdy;
  logic        typ1_val, typ1_sop, typ1_eop, typ1_rdy;
  logic        ign_val, ign_rdy;
  logic        err_len, err_sop;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  zcash_fpga_cmd_rx #(.MAX_LEN(MAX_LEN), .ERR_CNT_BITS(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_dat(rx_dat), .i_rx_val(rx_val), .i_rx_sop(rx_sop), .i_rx_eop(rx_eop),
    .o_rx_rdy(rx_rdy),
    .o_typ0_dat(typ0_dat), .o_typ0_val(typ0_val), .o_typ0_sop(typ0_sop),
    .o_typ0_eop(typ0_eop), .i_typ0_rdy(typ0_rdy),
    .o_typ1_dat(typ1_dat), .o_typ1_val(typ1_val), .o_typ1_sop(typ1_sop),
    .o_typ1_eop(typ1_eop), .i_typ1_rdy(typ1_rdy),
    .o_ign_hdr(ign_hdr), .o_ign_val(ign_val), .i_ign_rdy(ign_rdy),
    .o_err_len(err_len), .o_err_sop(err_sop), .o_err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [63:0] dat;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [63:0] qi[$];
  beat_t       b0, b1;

  int total = 0;
  int bad = 0;
  int err_len_seen = 0, err_sop_seen = 0;
  int err_len_exp = 0, err_sop_exp = 0;
  int ecnt_mdl = 0;
  int ign_delay = 2;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  function automatic void fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endfunction

  // Reference rules, straight from the command table.
  function automatic int mdl_route(logic [31:0] cmd, logic [31:0] len);
    if (len < 32'd8 || len > 32'(MAX_LEN)) return 2;
    if (cmd == 32'h0 || cmd == 32'h1) return 0;
    if (cmd == 32'h100 || cmd == 32'h101) return 1;
    return 2;
  endfunction

  function automatic int mdl_exp(logic [31:0] len);
    return int'((64'(len) + 64'd7) / 64'd8);
  endfunction

  function automatic void ecnt_inc();
    if (ecnt_mdl < 65535) ecnt_mdl++;
  endfunction

  // Sinks: random backpressure.
  initial begin
    typ0_rdy = 1'b0;
    typ1_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      typ0_rdy = 1'($urandom_range(0, 1));
      typ1_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Reply builder: accepts an ignore request ign_delay cycles after it appears.
  initial begin
    int wait_cnt;
    ign_rdy  = 1'b0;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (ign_val && !ign_rdy) begin
        if (wait_cnt >= ign_delay) ign_rdy = 1'b1;
        else wait_cnt++;
      end else begin
        ign_rdy  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("one_route", 64'(typ0_val & typ1_val), 64'd0);
        if (typ0_val) check("rdy_mirror0", 64'(rx_rdy), 64'(typ0_rdy));
        if (typ1_val) check("rdy_mirror1", 64'(rx_rdy), 64'(typ1_rdy));
        if (typ0_val && typ0_rdy) begin
          if (q0.size() == 0) fail_now("typ0_unexpected");
          else begin
            b0 = q0.pop_front();
            check("typ0_dat", typ0_dat, b0.dat);
            check("typ0_sop", 64'(typ0_sop), 64'(b0.sop));
            check("typ0_eop", 64'(typ0_eop), 64'(b0.eop));
          end
        end
        if (typ1_val && typ1_rdy) begin
          if (q1.size() == 0) fail_now("typ1_unexpected");
          else begin
            b1 = q1.pop_front();
            check("typ1_dat", typ1_dat, b1.dat);
            check("typ1_sop", 64'(typ1_sop), 64'(b1.sop));
            check("typ1_eop", 64'(typ1_eop), 64'(b1.eop));
          end
        end
        if (ign_val) begin
          check("ign_stall", 64'(rx_rdy), 64'd0);
          if (qi.size() == 0) fail_now("ign_unexpected");
          else begin
            check("ign_hdr", ign_hdr, qi[0]);
            if (ign_rdy) void'(qi.pop_front());
          end
        end
        if (err_len) err_len_seen++;
        if (err_sop) err_sop_seen++;
      end
    end
  end

  // Present one word and hold it until it transfers.
  task automatic send_word(input logic [63:0] dat, input logic sop, input logic eop);
    bit ok;
    int guard;
    rx_dat = dat;
    rx_sop = sop;
    rx_eop = eop;
    rx_val = 1'b1;
    ok     = 1'b0;
    guard  = 0;
    while (!ok) begin
      @(negedge clk);
      ok = rx_rdy;
      @(posedge clk); #1;
      guard++;
      if (!ok && guard > 1000) begin
        fail_now("rx_stall_timeout");
        ok = 1'b1;
      end
    end
    rx_val = 1'b0;
  endtask

  // Send a packet of n words (eop on the last) and record what must come out.
  task automatic send_pkt(input logic [63:0] hdr, input int n);
    int r, e, nf;
    logic [63:0] d;
    logic s;
    r  = mdl_route(hdr[63:32], hdr[31:0]);
    e  = (r == 2) ? 0 : mdl_exp(hdr[31:0]);
    nf = (n < e) ? n : e;
    if (r == 2) begin
      qi.push_back(hdr);
      ecnt_inc();
    end else if (n != e) begin
      err_len_exp++;
      ecnt_inc();
    end
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? hdr : {$urandom(), $urandom()};
      s = (i == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      if (r != 2 && i < nf) begin
        if (r == 0) q0.push_back({d, (i == 0), (i == nf - 1)});
        else        q1.push_back({d, (i == 0), (i == nf - 1)});
      end
      send_word(d, s, (i == n - 1));
    end
  endtask

  task automatic stray_word();
    err_sop_exp++;
    ecnt_inc();
    send_word({$urandom(), $urandom()}, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Wait for the scoreboard to empty, then compare the error bookkeeping.
  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0 || qi.size() != 0 || ign_val) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 500) fail_now({tag, "_drain_timeout"});
    repeat (2) begin
      @(posedge clk); #1;
    end
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(ecnt_mdl));
    check({tag, "_err_len_pulses"}, 64'(err_len_seen), 64'(err_len_exp));
    check({tag, "_err_sop_pulses"}, 64'(err_sop_seen), 64'(err_sop_exp));
  endtask

  initial begin
    logic [31:0] cmd, len;
    int r, e, n;
    rst_n  = 1'b0;
    rx_dat = '0;
    rx_val = 1'b0;
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_typ0_val", 64'(typ0_val), 64'd0);
    check("rst_ign_hdr", ign_hdr, 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy", 64'(rx_rdy), 64'd1);
    check("idle_vals", 64'({typ0_val, typ1_val, ign_val, err_len, err_sop}), 64'd0);

    // Directed cases.
    send_pkt(64'h00000001_00000008, 1);
    drain("status");
    send_pkt(64'h00000101_000000B0, 22);
    drain("secp");
    ign_delay = 5;
    send_pkt(64'h00000002_00000010, 2);
    drain("unknown");
    check("unknown_ign_hdr_kept", ign_hdr, 64'h00000002_00000010);
    send_pkt(64'h00000100_00000010, 4);
    drain("long");
    send_pkt(64'h00000100_00000028, 3);
    drain("short");
    stray_word();
    drain("stray");

    // Randomized packets.
    for (int k = 0; k < 40; k++) begin
      ign_delay = $urandom_range(0, 4);
      case ($urandom_range(0, 6))
        0: cmd = 32'h0;
        1: cmd = 32'h1;
        2: cmd = 32'h100;
        3: cmd = 32'h101;
        4: cmd = 32'h2;
        5: cmd = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: cmd = $urandom();
      endcase
      case ($urandom_range(0, 5))
        0: len = 32'($urandom_range(0, 7));
        1: len = 32'd8;
        2: len = 32'(MAX_LEN);
        3: len = 32'(MAX_LEN + 1 + $urandom_range(0, 100));
        default: len = 32'($urandom_range(9, 200));
      endcase
      r = mdl_route(cmd, len);
      if (r == 2) n = $urandom_range(1, 3);
      else begin
        e = mdl_exp(len);
        if (e == 1) n = 1;
        else case ($urandom_range(0, 2))
          0: n = e;
          1: n = $urandom_range(1, e - 1);
          default: n = e + $urandom_range(1, 3);
        endcase
      end
      if ($urandom_range(0, 5) == 0) stray_word();
      send_pkt({cmd, len}, n);
      drain("rand");
    end

    // Saturation of the error counter.
    rx_dat = 64'h1234;
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    rx_val = 1'b1;
    repeat (65540) begin
      @(posedge clk);
      err_sop_exp++;
      ecnt_inc();
    end
    #1;
    rx_val = 1'b0;
    drain("sat");
    check("sat_value", 64'(err_cnt), 64'hFFFF);
    ign_delay = 1;
    send_pkt(64'h00000003_00000010, 2);
    drain("sat_hold");

    // Reset in the middle of a forwarded packet.
    q1.push_back({64'h00000100_00000040, 1'b1, 1'b0});
    send_word(64'h00000100_00000040, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) begin
      logic [63:0] d;
      d = {$urandom(), $urandom()};
      q1.push_back({d, 1'b0, 1'b0});
      send_word(d, 1'b0, 1'b0);
    end
    rx_dat = {$urandom(), $urandom()};
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    rx_val = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_typ1_val", 64'(typ1_val), 64'd0);
    check("midrst_pulses", 64'({typ0_val, ign_val, err_len, err_sop, rx_rdy}), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_ign_hdr", ign_hdr, 64'd0);
    rx_val = 1'b0;
    ecnt_mdl = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) stray_word();
    drain("after_rst_leftover");
    send_pkt(64'h00000000_00000008, 1);
    send_pkt(64'h00000101_000000B0, 22);
    drain("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zcash_fpga_cmd_rx.md
Name: zcash_fpga_cmd_rx

Overview:
- Host-to-FPGA command receiver and dispatcher; the inbound counterpart of the reply builders in zcash_fpga_pkg.
- Takes the 64-bit host stream and decodes header_t (cmd [63:32], len [31:0] in bytes, header included) from each packet's first word.
- Routes the packet to the control handler (typ0) or the verify engines (typ1). Drops malformed or unsupported packets and requests an FPGA_IGNORE_RPL carrying the offending header.

Parameters:
- MAX_LEN, 2048, largest accepted len in bytes; a header with a larger len is dropped.
- ERR_CNT_BITS, 16, width of the saturating error counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_dat  in  64  host stream word
- i_rx_val  in  1  word valid
- i_rx_sop  in  1  first word of packet
- i_rx_eop  in  1  last word of packet
- o_rx_rdy  out  1  receiver accepts word
- o_typ0_dat  out  64  control stream (RESET_FPGA, FPGA_STATUS)
- o_typ0_val / o_typ0_sop / o_typ0_eop  out  1 each  control stream framing
- i_typ0_rdy  in  1  control sink ready
- o_typ1_dat / o_typ1_val / o_typ1_sop / o_typ1_eop  out  64/1/1/1  verify stream (VERIFY_EQUIHASH, VERIFY_SECP256K1_SIG)
- i_typ1_rdy  in  1  verify sink ready
- o_ign_hdr  out  64  header_t to embed in the ignore reply
- o_ign_val  out  1  ignore request
- i_ign_rdy  in  1  reply builder accepted the request
- o_err_len  out  1  one-cycle pulse on length/eop mismatch
- o_err_sop  out  1  one-cycle pulse on a word received in IDLE without sop
- o_err_cnt  out  ERR_CNT_BITS  saturating count of ignores and errors

Behaviour:
- Reset (async assert, sync release): state IDLE; all valids, error pulses, o_ign_hdr and o_err_cnt are 0.
- Transfer rule: a word transfers when i_rx_val && o_rx_rdy.
- Datapath is combinational pass-through with zero latency. o_rx_rdy equals the selected sink's rdy in FWD; it is 1 in IDLE and DROP and 0 in IGN.
- Route decode (pure function of the header):
  - ROUTE_TYP0: cmd RESET_FPGA or FPGA_STATUS.
  - ROUTE_TYP1: VERIFY_EQUIHASH when ENB_VERIFY_EQUIHASH; VERIFY_SECP256K1_SIG when ENB_VERIFY_SECP256K1_SIG.
  - ROUTE_DROP: anything else, including reply codes (bit31 set) and disabled features.
  - Any cmd also becomes ROUTE_DROP if len < 8 or len > MAX_LEN.
- Expected word count exp = (len+7)>>3, held in a 16-bit register. The word counter cnt starts at 1 on the header word.
- IDLE:
  - Valid word without sop: drop it, pulse o_err_sop, increment err_cnt.
  - sop with route TYP0/TYP1: forward the header word. The sink's rdy gates o_rx_rdy in this cycle too. If exp==1, assert eop and stay in IDLE; otherwise go to FWD.
  - sop with ROUTE_DROP: latch the header into o_ign_hdr. If i_rx_eop, go to IGN; otherwise go to DROP.
- FWD: forward each word and increment cnt.
  - Output eop = (cnt==exp) || i_rx_eop.
  - i_rx_eop with cnt==exp: normal end, go to IDLE.
  - i_rx_eop with cnt<exp: short packet. Forward the word with eop, pulse o_err_len, go to IDLE.
  - cnt==exp without i_rx_eop: long packet. Forward the word with eop forced, pulse o_err_len, go to DROP without ignore (flag no_ign=1).
  - i_rx_sop in FWD is ignored and treated as data.
- DROP: consume words with no output. On i_rx_eop, go to IGN, or to IDLE if no_ign.
- IGN: o_ign_val=1 with o_ign_hdr stable. On i_ign_rdy, increment err_cnt and go to IDLE. o_rx_rdy=0 throughout, so only one ignore is ever pending.
- err_cnt increments once per ignore, o_err_len or o_err_sop and saturates at all-ones. Simultaneous events in one cycle add 1.
- Reset mid-packet: the packet is abandoned. Words that follow before the next sop produce o_err_sop pulses.
- Only the active route's val may be high. Output dat/sop/eop are don't-care when val=0.

Decomposition:
- zcash_fpga_pkg gains:
  - typedef enum rx_route_t {ROUTE_TYP0, ROUTE_TYP1, ROUTE_DROP};
  - function get_rx_route(header_t hdr, int max_len), combinational, reusing command_t and the ENB_* parameters;
  - function hdr_words(header_t) returning (len+7)>>3.
- No sub-module: one FSM with a counter.

Test Plan:
- Word 0x00000001_00000008 with sop+eop -> single typ0 word, sop=eop=1, no typ1/ign activity, err_cnt 0.
- VERIFY_SECP256K1_SIG, header 0x00000101_000000B0, 22 words -> 22 typ1 words, eop on word 22 only; i_typ1_rdy toggled 50% -> no loss or duplication, o_rx_rdy mirrors rdy.
- Unknown cmd 0x00000002_00000010, 2 words -> nothing forwarded; o_ign_hdr=0x00000002_00000010 held until i_ign_rdy (delay 5 cycles, rx stalled); err_cnt=1.
- VERIFY_EQUIHASH header with len 16, host eop on word 4 -> 2 typ1 words with eop on word 2, words 3-4 dropped, one o_err_len pulse, no ignore, err_cnt=1. Also len 40 with eop on word 3 -> eop forwarded on word 3, o_err_len.
- Non-sop word in IDLE -> o_err_sop pulse, no output. 0xFFFF errors injected -> o_err_cnt stays 0xFFFF.
- i_rst_n asserted mid-FWD -> outputs 0 immediately. Next valid sop packet routes correctly; leftover words flag o_err_sop.
